reg_bank: RTL and testbench

- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- It is the write-side endpoint of the destination-register selection path: it consumes the 5-bit write index, the write enable and the write data.
- It also supplies the two source operands to the A/B operand stage.
- Read data is registered, giving a one-cycle read latency that matches the multicycle control timing.

---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/reg_read_port.sv | 49 ++++
 rtl/reg_bank.sv | 87 ++++++++
 tb/tb_reg_bank.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the MIPS register bank, the write-register mux and the write-back mux.
package reg_bank_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 32;
    localparam int REG_ZERO     = 0;
    localparam int REG_SP       = 29;
    localparam int SP_RESET_VAL = 227;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port of the register bank; the same-edge write bypass is
// compiled in only when REG_BANK_WRITE_BYPASS_EN is defined.
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  bank,
    input  logic [ADDR_W-1:0]                read_reg,
`ifdef REG_BANK_WRITE_BYPASS_EN
    input  logic                             reg_write,
    input  logic [ADDR_W-1:0]                write_reg,
    input  logic [DATA_W-1:0]                write_data,
`endif
    output logic [DATA_W-1:0]                read_data
);

    logic [DATA_W-1:0] read_next_s;
    logic [DATA_W-1:0] read_data_r;

    // Read mux, with the optional forward of this edge's write data.
    always_comb begin
        read_next_s = bank[read_reg];
`ifdef REG_BANK_WRITE_BYPASS_EN
        // bank[0] is hard-wired zero, and index 0 must never pick up a bypassed value.
        if (reg_write && (write_reg != ADDR_W'(REG_ZERO)) && (read_reg == write_reg)) begin
            read_next_s = write_data;
        end else begin
            read_next_s = bank[read_reg];
        end
`endif
    end

    // Output register, giving the one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_r <= {DATA_W{1'b0}};
        end else begin
            read_data_r <= read_next_s;
        end
    end

    assign read_data = read_data_r;

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS register file with two registered read ports.
// Optional macro REG_BANK_WRITE_BYPASS_EN forwards same-edge write data to the read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int SP_INDEX = reg_bank_pkg::REG_SP,
    parameter int SP_RESET = reg_bank_pkg::SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    // Entry 0 is never stored; only entries 1..NUM_REGS-1 are real flops.
    logic [DATA_W-1:0]                regs_r [1:NUM_REGS-1];
    logic [NUM_REGS-1:0][DATA_W-1:0]  bank_s;

    // Storage array: async reset to zero except the stack pointer, gated writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (reg_write && (write_reg == ADDR_W'(i))) begin
                    regs_r[i] <= write_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Flat view of the bank for the read muxes, with entry 0 tied to zero.
    always_comb begin
        bank_s[REG_ZERO] = {DATA_W{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            bank_s[i] = regs_r[i];
        end
    end

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port1 (
        .clk        (clk),
        .reset      (reset),
        .bank       (bank_s),
        .read_reg   (read_reg1),
`ifdef REG_BANK_WRITE_BYPASS_EN
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
`endif
        .read_data  (read_data1)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port2 (
        .clk        (clk),
        .reset      (reset),
        .bank       (bank_s),
        .read_reg   (read_reg2),
`ifdef REG_BANK_WRITE_BYPASS_EN
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
`endif
        .read_data  (read_data2)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table plus reset sequences.
// Expectations follow REG_BANK_WRITE_BYPASS_EN when it is defined.
module tb_reg_bank;

`ifdef REG_BANK_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    reg_bank dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rr1, input logic [4:0] rr2,
                         input logic [4:0] wr, input logic [31:0] wd);
        reg_write  = we;
        read_reg1  = rr1;
        read_reg2  = rr2;
        write_reg  = wr;
        write_data = wd;
    endtask

    initial begin
        // we, rr1, rr2, wr, wd, exp read_data1, exp read_data2
        vecs[0]  = '{1'b0, 5'd29, 5'd5,  5'd0,  32'h0000_0000, 32'd227, 32'h0};
        vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd8,  32'hDEAD_BEEF,
                     BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0};
        vecs[2]  = '{1'b0, 5'd8,  5'd29, 5'd0,  32'h0000_0000, 32'hDEAD_BEEF, 32'd227};
        vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 5'd9,  5'd9,  5'd9,  32'h0000_1234, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 5'd9,  5'd8,  5'd0,  32'h0000_0000, 32'h0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 5'd1,  5'd2,  5'd10, 32'h0000_0011, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 5'd10, 5'd29, 5'd10, 32'h0000_0022,
                     BYP ? 32'h22 : 32'h11, 32'd227};
        vecs[9]  = '{1'b0, 5'd10, 5'd10, 5'd0,  32'h0000_0000, 32'h22, 32'h22};
        vecs[10] = '{1'b1, 5'd31, 5'd30, 5'd31, 32'hA5A5_A5A5,
                     BYP ? 32'hA5A5_A5A5 : 32'h0, 32'h0};
        vecs[11] = '{1'b0, 5'd31, 5'd30, 5'd0,  32'h0000_0000, 32'hA5A5_A5A5, 32'h0};

        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("rst_imm_rd1", read_data1, 32'h0);
        check("rst_imm_rd2", read_data2, 32'h0);

        // Reset held across an edge: outputs stay zero and the write is ignored.
        drive(1'b1, 5'd29, 5'd4, 5'd4, 32'h0000_0077);
        @(posedge clk); #1;
        check("rst_hold_rd1", read_data1, 32'h0);
        check("rst_hold_rd2", read_data2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd4, 5'd4, 5'd0, 32'h0);
        @(posedge clk); #1;
        check("rst_nowrite_r4", read_data1, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rr1, vecs[i].rr2, vecs[i].wr, vecs[i].wd);
            @(posedge clk); #1;
            check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].e2);
        end

        // Same-edge read/write: the new value must be visible one edge later in any build.
        @(negedge clk);
        drive(1'b0, 5'd10, 5'd0, 5'd0, 32'h0);
        @(posedge clk); #1;
        check("rw_after_rd1", read_data1, 32'h22);

        // Async reset mid-cycle after writes to r3 and SP.
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'd3, 32'h0000_0055);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'd29, 32'h0000_0100);
        @(negedge clk);
        drive(1'b0, 5'd3, 5'd29, 5'd0, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_r3", read_data1, 32'h55);
        check("pre_rst_sp", read_data2, 32'h100);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rd1", read_data1, 32'h0);
        check("mid_rst_rd2", read_data2, 32'h0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_r3", read_data1, 32'h0);
        check("post_rst_sp", read_data2, 32'd227);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
